// File: rtl/mpmodred256_pkg.sv
// Shared constants and types for the word-serial P-256 modular reduction stage.
package mpmod_pkg;

    localparam logic [255:0] P256_P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    localparam int WORD_W_DEF = 32;

    function automatic int nw(input int word_w);
        return 256 / word_w;
    endfunction

    localparam int NW = nw(WORD_W_DEF);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

endpackage

// File: rtl/mpmodred256_sub.sv
// One word of the ripple-borrow subtractor: {bout, d} = a - b - bin.
module mpsub_word #(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              bin,
    output logic [WORD_W-1:0] d,
    output logic              bout
);

    logic [WORD_W:0] diff;

    // A negative result leaves the extra top bit set, which is the borrow out.
    assign diff = {1'b0, a} - {1'b0, b} - {{WORD_W{1'b0}}, bin};
    assign d    = diff[WORD_W-1:0];
    assign bout = diff[WORD_W];

endmodule

// File: rtl/mpmodred256.sv
// Word-serial s mod p by one conditional subtraction of the P-256 prime.
// Optional `reduced` flag output enabled by defining MPMODRED_FLAG_EN.
module mpmodred256
    import mpmod_pkg::*;
#(
    parameter int           WORD_W  = WORD_W_DEF,
    parameter logic [255:0] MODULUS = P256_P
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [256:0] s_in,
    input  logic         write,
    input  logic         start,
    output logic [255:0] r_out,
`ifdef MPMODRED_FLAG_EN
    output logic         reduced,
`endif
    output logic         ready
);

    localparam int NWORDS = nw(WORD_W);
    localparam int K_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t             state, next_state;
    logic [K_W-1:0]     k;
    logic               borrow;
    logic [256:0]       sreg;
    logic [255:0]       dreg;
    logic [255:0]       dnext;
    logic [WORD_W-1:0]  a_word, p_word, d_word;
    logic               bout;
    logic               sel;
    logic               ld_op, go, step, last;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic: write beats start, both ignored while subtracting
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (write)      next_state = IDLE;
                else if (start) next_state = SUB;
            end
            SUB:     if (last) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Control strobes
    always_comb begin
        ld_op = 1'b0;
        go    = 1'b0;
        step  = 1'b0;
        last  = 1'b0;
        case (state)
            IDLE, DONE: begin
                ld_op = write;
                go    = start & ~write;
            end
            SUB: begin
                step = 1'b1;
                last = (k == K_W'(NWORDS - 1));
            end
            default: ;
        endcase
    end

    assign a_word = sreg[int'(k)*WORD_W +: WORD_W];
    assign p_word = MODULUS[int'(k)*WORD_W +: WORD_W];

    mpsub_word #(.WORD_W(WORD_W)) u_sub (
        .a    (a_word),
        .b    (p_word),
        .bin  (borrow),
        .d    (d_word),
        .bout (bout)
    );

    // The top difference word is not in dreg yet on the last cycle, so merge it in.
    always_comb begin
        dnext = dreg;
        dnext[int'(k)*WORD_W +: WORD_W] = d_word;
    end

    assign sel = sreg[256] | ~bout;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sreg   <= '0;
            dreg   <= '0;
            borrow <= 1'b0;
            k      <= '0;
            r_out  <= '0;
            ready  <= 1'b0;
        end else if (ld_op) begin
            sreg  <= s_in;
            ready <= 1'b0;
        end else if (go) begin
            k      <= '0;
            borrow <= 1'b0;
            ready  <= 1'b0;
        end else if (step) begin
            dreg   <= dnext;
            borrow <= bout;
            k      <= k + 1'b1;
            if (last) begin
                k     <= '0;
                r_out <= sel ? dnext : sreg[255:0];
                ready <= 1'b1;
            end
        end
    end

`ifdef MPMODRED_FLAG_EN
    always_ff @(posedge CLK) begin
        if (!RST_N)              reduced <= 1'b0;
        else if (ld_op || go)    reduced <= 1'b0;
        else if (step && last)   reduced <= sel;
    end
`endif

endmodule

// File: tb/tb_mpmodred256.sv
// Self-checking bench for mpmodred256: vector table, handshake corners, random adder chain.
module tb_mpmodred256;

    localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam logic [256:0] PX = {1'b0, P};

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [256:0] s_in = '0;
    logic         write = 1'b0;
    logic         start = 1'b0;
    logic [255:0] r_out;
    logic         ready;
`ifdef MPMODRED_FLAG_EN
    logic         reduced;
`endif

    mpmodred256 dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .s_in    (s_in),
        .write   (write),
        .start   (start),
        .r_out   (r_out),
`ifdef MPMODRED_FLAG_EN
        .reduced (reduced),
`endif
        .ready   (ready)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [256:0] s;
        logic [255:0] r;
        logic         red;
    } vec_t;

    typedef struct {
        logic [255:0] r;
        logic         red;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [256:0] act, input logic [256:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic check_result(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({nm, "_queue"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_r"}, {1'b0, r_out}, {1'b0, e.r});
`ifdef MPMODRED_FLAG_EN
            chk({nm, "_red"}, reduced, e.red);
`endif
        end
    endtask

    task automatic run_op(input string nm, input logic [256:0] s, input logic [255:0] er, input logic ered);
        int n;
        exp_t e;
        s_in  = s;
        write = 1'b1;
        tick();
        write = 1'b0;
        start = 1'b1;
        e.r = er;
        e.red = ered;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        chk({nm, "_rdy_drop"}, ready, 0);
        wait_ready(n);
        chk({nm, "_lat"}, n, 8);
        check_result(nm);
    endtask

    initial begin
        int n;
        exp_t e;
        logic [255:0] a, b, last_r;
        logic [256:0] sum;

        vecs[0] = '{257'd0, 256'd0, 1'b0};
        vecs[1] = '{PX, 256'd0, 1'b1};
        vecs[2] = '{PX - 257'd1, P - 256'd1, 1'b0};
        vecs[3] = '{257'h1_FFFFFFFE00000002000000000000000000000001FFFFFFFFFFFFFFFFFFFFFFFD, P - 256'd1, 1'b1};
        vecs[4] = '{PX + 257'd1, 256'd1, 1'b1};
        vecs[5] = '{{1'b1, 256'd0}, 256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000001, 1'b1};

        tick();
        tick();
        chk("reset_ready", ready, 0);
        chk("reset_r", r_out, 0);
`ifdef MPMODRED_FLAG_EN
        chk("reset_red", reduced, 0);
`endif
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].r, vecs[i].red);

        // ready and r_out hold in DONE
        last_r = vecs[5].r;
        repeat (5) tick();
        chk("done_hold_rdy", ready, 1);
        chk("done_hold_r", r_out, last_r);

        // write and start together: load only, no subtraction
        s_in  = PX + 257'd3;
        write = 1'b1;
        start = 1'b1;
        tick();
        write = 1'b0;
        start = 1'b0;
        chk("ws_rdy_drop", ready, 0);
        chk("ws_r_keep", r_out, last_r);
        repeat (12) tick();
        chk("ws_no_sub", ready, 0);
        start = 1'b1;
        e.r = 256'd3;
        e.red = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        wait_ready(n);
        chk("ws_lat", n, 8);
        check_result("ws");

        // start and write pulsed mid-SUB are ignored
        s_in  = PX + 257'd5;
        write = 1'b1;
        tick();
        write = 1'b0;
        start = 1'b1;
        e.r = 256'd5;
        e.red = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            if (n == 3) begin
                start = 1'b1;
                write = 1'b1;
                s_in  = 257'd9;
            end else begin
                start = 1'b0;
                write = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        write = 1'b0;
        chk("midsub_lat", n, 8);
        check_result("midsub");

        // start in DONE without write recomputes the same operand
        start = 1'b1;
        e.r = 256'd5;
        e.red = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        chk("recomp_rdy_drop", ready, 0);
        wait_ready(n);
        chk("recomp_lat", n, 8);
        check_result("recomp");

        // reset during SUB cycle 4 discards the result
        s_in  = PX + 257'd7;
        write = 1'b1;
        tick();
        write = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        chk("rst_mid_rdy", ready, 0);
        chk("rst_mid_r", r_out, 0);
`ifdef MPMODRED_FLAG_EN
        chk("rst_mid_red", reduced, 0);
`endif
        repeat (12) tick();
        chk("rst_mid_stay", ready, 0);

        // adder chain: (a + b) mod p for operands below p
        for (int t = 0; t < 1000; t++) begin
            for (int w = 0; w < 8; w++) begin
                a[w*32 +: 32] = $urandom;
                b[w*32 +: 32] = $urandom;
            end
            if (a >= P) a = a - P;
            if (b >= P) b = b - P;
            sum = {1'b0, a} + {1'b0, b};
            run_op($sformatf("rnd%0d", t), sum, 256'(sum % PX), sum >= PX);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
